// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, issues one word fetch at
// a time to instruction memory, and hands each returned word together with its
// PC to decode through a one-entry registered output slot. A one-cycle
// redirect (taken branch / JAL / JALR) replaces the PC and flushes both the
// output slot and any fetch already in flight.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   imem_req_valid   fetch request valid (combinational)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    fetch address, always word aligned (equals pc)
//   imem_rsp_valid   response valid; one per accepted request, in order
//   imem_rsp_data    fetched instruction word
//   inst_valid       inst / inst_pc hold a valid instruction for decode
//   inst_ready       decode consumes inst this cycle
//   inst             instruction word (NOP_INST while the slot is empty)
//   inst_pc          PC of inst
//   redirect         one-cycle pulse: continue fetching at redirect_target
//   redirect_target  new PC, bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  // REQ : free to issue the next fetch
  // WAIT: fetch outstanding, its word will be delivered
  // DROP: fetch outstanding but flushed by a redirect, its word is discarded
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_inflight_reg, pc_inflight_next;
  logic        inst_valid_reg, inst_valid_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;

  logic        slot_free;
  logic        req_fire;
  logic        fill;
  logic        consume;

  // The slot counts as free when it is empty or being drained this cycle, so
  // a consume and a new issue can overlap. Reset and redirect both suppress
  // issue; the reset term keeps the request low while rst_n is held.
  assign slot_free      = !inst_valid_reg || inst_ready;
  assign imem_req_valid = rst_n && (state_reg == ST_REQ) && !redirect && slot_free;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response lands in the slot only while a live fetch is outstanding and
  // no redirect is flushing it in the same cycle.
  assign fill    = (state_reg == ST_WAIT) && imem_rsp_valid && !redirect;
  assign consume = inst_valid_reg && inst_ready;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pc_inflight_next = pc_inflight_reg;
    inst_valid_next  = inst_valid_reg;
    inst_next        = inst_reg;
    inst_pc_next     = inst_pc_reg;

    if (redirect) begin
      pc_next         = redirect_target & WORD_MASK;
      inst_valid_next = 1'b0;
      inst_next       = NOP_INST;
      // An outstanding fetch must still be retired: if its response is not
      // arriving right now, wait for it in DROP and throw it away.
      case (state_reg)
        ST_WAIT, ST_DROP: state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
        default:          state_next = ST_REQ;
      endcase
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (req_fire) begin
            pc_inflight_next = pc_reg;
            pc_next          = pc_reg + 32'd4;
            state_next       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_next = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            state_next = ST_REQ;
          end
        end
        default: begin
          state_next = ST_REQ;
        end
      endcase

      // Output slot: a fill wins over a consume, so the slot takes the new
      // word when both happen in the same cycle.
      if (fill) begin
        inst_valid_next = 1'b1;
        inst_next       = imem_rsp_data;
        inst_pc_next    = pc_inflight_reg;
      end else if (consume) begin
        inst_valid_next = 1'b0;
        inst_next       = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_REQ;
      pc_reg          <= RESET_PC & WORD_MASK;
      pc_inflight_reg <= RESET_PC & WORD_MASK;
      inst_valid_reg  <= 1'b0;
      inst_reg        <= NOP_INST;
      inst_pc_reg     <= 32'h0000_0000;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pc_inflight_reg <= pc_inflight_next;
      inst_valid_reg  <= inst_valid_next;
      inst_reg        <= inst_next;
      inst_pc_reg     <= inst_pc_next;
    end
  end

  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Scoreboard bench for fetch_unit. The stimulus side pushes the expected
// program-order PC stream into a queue whenever it starts a stream (reset or
// redirect); an independent monitor pops that queue each time decode consumes
// an instruction. A memory model answers fetches with 0xAAAA0000 + addr.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_target;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect       (redirect),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard / reference model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  int          deliver_cnt = 0;

  // memory model state
  bit          pending = 0;
  int          wait_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          lat_fixed = 0;
  bit          lat_rand = 0;
  bit          ready_rand = 0;

  // monitor history
  bit          prev_stall = 0;
  bit          prev_redir = 0;
  logic [31:0] prev_inst = 32'h0;
  logic [31:0] prev_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Program order from a start address: sequential words, wrapping mod 2^32.
  task automatic restart_stream(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(base + 32'(4 * i));
    exp_fetch = base;
  endtask

  // Memory response driver: answers the outstanding fetch after wait_cnt
  // idle cycles; ready is either held high or randomised.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending        = 0;
        imem_rsp_valid = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
        if (pending) begin
          if (wait_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
          end else begin
            wait_cnt--;
          end
        end
        imem_req_ready = ready_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
      end
    end
  end

  // Monitor: samples on the falling edge, after inputs for the cycle are set.
  initial begin
    logic [31:0] e;
    bit fire;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_redir = 0;
      end else begin
        fire = imem_req_valid && imem_req_ready;
        if (prev_redir)
          check("flush_clears_slot", !inst_valid && inst == NOP, inst, NOP);
        if (prev_stall) begin
          check("stall_valid_held", inst_valid, {31'h0, inst_valid}, 32'h1);
          check("stall_inst_held", inst == prev_inst, inst, prev_inst);
          check("stall_pc_held", inst_pc == prev_pc, inst_pc, prev_pc);
        end
        if (!inst_valid)
          check("empty_slot_nop", inst == NOP, inst, NOP);
        if (redirect)
          check("redirect_blocks_req", !imem_req_valid, {31'h0, imem_req_valid}, 32'h0);
        if (imem_rsp_valid) pending = 0;
        if (fire) begin
          check("one_outstanding", !pending, {31'h0, pending}, 32'h0);
          check("fetch_addr", imem_req_addr == exp_fetch, imem_req_addr, exp_fetch);
          check("no_issue_when_full", !(inst_valid && !inst_ready),
                {31'h0, inst_valid}, {31'h0, inst_ready});
          exp_fetch = exp_fetch + 32'd4;
          pending   = 1;
          wait_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
          pend_addr = imem_req_addr;
        end
        if (inst_valid && inst_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1'b0, inst_pc, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("deliver_pc", inst_pc == e, inst_pc, e);
            check("deliver_data", inst == mem_word(e), inst, mem_word(e));
          end
          deliver_cnt++;
        end
        prev_stall = inst_valid && !inst_ready && !redirect;
        prev_redir = redirect;
        prev_inst  = inst;
        prev_pc    = inst_pc;
      end
    end
  end

  task automatic wait_fire(input string name, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        found = 1;
        break;
      end
    end
    check(name, found, {31'h0, found}, 32'h1);
  endtask

  task automatic wait_deliveries(input string name, input int count, input int budget);
    int target;
    bit found;
    target = deliver_cnt + count;
    found  = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (deliver_cnt >= target) begin
        found = 1;
        break;
      end
    end
    check(name, found, 32'(deliver_cnt), 32'(target));
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect        = 1'b1;
    redirect_target = t;
    restart_stream(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, !imem_req_valid, {31'h0, imem_req_valid}, 32'h0);
    check({tag, "_inst_valid"}, !inst_valid, {31'h0, inst_valid}, 32'h0);
    check({tag, "_inst"}, inst == NOP, inst, NOP);
    check({tag, "_inst_pc"}, inst_pc == 32'h0, inst_pc, 32'h0);
    check({tag, "_req_addr"}, imem_req_addr == RESET_PC, imem_req_addr, RESET_PC);
  endtask

  // Stimulus
  initial begin
    bit found;
    logic [31:0] t;
    rst_n           = 1'b1;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    inst_ready      = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    restart_stream(RESET_PC);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req_after_reset", imem_req_valid && imem_req_addr == RESET_PC,
          imem_req_addr, RESET_PC);

    // straight-line fetch of 0x0, 0x4, 0x8
    wait_deliveries("initial_stream", 3, 40);

    // decode stall: slot holds, no issue; issue resumes with the drain
    @(posedge clk);
    #1 inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        found = 1;
        break;
      end
    end
    check("stall_slot_filled", found, {31'h0, found}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_req", !imem_req_valid, {31'h0, imem_req_valid}, 32'h0);
    end
    @(posedge clk);
    #1 inst_ready = 1'b1;
    @(negedge clk);
    check("release_issues_same_cycle", imem_req_valid && imem_req_ready,
          {31'h0, imem_req_valid}, 32'h1);

    // redirect while waiting; stale response arrives 3 cycles later
    lat_fixed = 3;
    wait_fire("wait_fire_t3", 20);
    @(posedge clk);
    #1 pulse_redirect(32'h0000_0100);
    lat_fixed = 0;
    @(posedge clk);
    #1 redirect = 1'b0;
    wait_deliveries("redirect_wait_stream", 2, 40);

    // redirect in the same cycle as the response: no DROP wait
    wait_fire("wait_fire_t4", 20);
    @(posedge clk);
    #1 pulse_redirect(32'h0000_0203);
    @(negedge clk);
    check("t4_rsp_same_cycle", imem_rsp_valid, {31'h0, imem_rsp_valid}, 32'h1);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("t4_issue_without_drop", imem_req_valid && imem_req_addr == 32'h200,
          imem_req_addr, 32'h200);
    wait_deliveries("t4_stream", 2, 40);

    // redirect while the slot is valid and being consumed
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        found = 1;
        break;
      end
    end
    check("t5_slot_valid", found, {31'h0, found}, 32'h1);
    pulse_redirect(32'h0000_0400);
    @(negedge clk);
    check("t5_req_low", !imem_req_valid, {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1 redirect = 1'b0;
    check("t5_flushed", !inst_valid && inst == NOP, inst, NOP);
    wait_deliveries("t5_stream", 2, 40);

    // wrap from the top of the address space
    @(posedge clk);
    #1 pulse_redirect(32'hFFFF_FFFC);
    @(posedge clk);
    #1 redirect = 1'b0;
    wait_deliveries("wrap_stream", 3, 40);

    // asynchronous reset while a fetch is outstanding
    lat_fixed = 3;
    wait_fire("wait_fire_t7", 20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    restart_stream(RESET_PC);
    lat_fixed = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_deliveries("post_reset_stream", 3, 40);

    // randomised traffic
    lat_rand   = 1;
    ready_rand = 1;
    begin
      int d0;
      d0 = deliver_cnt;
      for (int i = 0; i < 2500; i++) begin
        @(posedge clk);
        #1;
        inst_ready = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 99) < 5) begin
          t = $urandom;
          if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
          pulse_redirect(t);
        end else begin
          redirect = 1'b0;
        end
      end
      @(posedge clk);
      #1 redirect = 1'b0;
      inst_ready = 1'b1;
      repeat (10) @(posedge clk);
      check("random_liveness", (deliver_cnt - d0) > 100, 32'(deliver_cnt - d0), 32'd101);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
